// File: rtl/genie_split_ex.sv
// rtl/genie_split_ex.sv - packet-aware one-to-many fork node with per-packet destination lock
module genie_split_ex #(
  parameter int NO    = 2,
  parameter int WIDTH = 1,
  // WIDTH=0 still needs a legal vector type; the 1-bit stub lane is never driven with data
  localparam int DW   = (WIDTH > 0) ? WIDTH : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_eop,
  input  logic [NO-1:0]    i_mask,
  output logic [NO-1:0]    o_valid,
  output logic [NO*DW-1:0] o_data,
  output logic [NO-1:0]    o_eop,
  input  logic [NO-1:0]    i_ready
);

  generate
    if (NO < 2) begin : g_bad_no
      $error("genie_split_ex: NO must be at least 2");
    end
  endgenerate

  // r_sent marks ports that already took the current beat; r_lock_mask holds the open packet's destinations
  logic [NO-1:0] r_sent;
  logic [NO-1:0] r_lock_mask;
  logic          r_in_pkt;

  logic [NO-1:0] w_eff;
  logic [NO-1:0] w_pend;
  logic [NO-1:0] w_acc;
  logic          w_done;

  // Destinations come from the live mask only on the head beat of a packet
  assign w_eff  = r_in_pkt ? r_lock_mask : i_mask;
  assign w_pend = w_eff & ~r_sent;

  // Beat completes when no selected, still-unserved port is refusing it this cycle
  assign w_done = i_valid & ((w_pend & ~i_ready) == '0);

  // Handshake outputs are forced low while reset is asserted, regardless of inputs
  assign o_valid = reset ? ({NO{i_valid}} & w_pend) : '0;
  assign o_ready = reset & w_done;
  assign w_acc   = o_valid & i_ready;

  assign o_eop = {NO{i_eop}};

  generate
    if (WIDTH > 0) begin : g_data
      assign o_data = {NO{i_data}};
    end else begin : g_nodata
      logic w_unused_data;
      assign w_unused_data = ^i_data;
      assign o_data = '0;
    end
  endgenerate

  // Track per-port service of the current beat and open/close the packet lock on consumed beats
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sent      <= '0;
      r_in_pkt    <= 1'b0;
      r_lock_mask <= '0;
    end else if (w_done) begin
      r_sent <= '0;
      if (i_eop) begin
        r_in_pkt <= 1'b0;
      end else begin
        r_in_pkt    <= 1'b1;
        r_lock_mask <= w_eff;
      end
    end else begin
      // A stalled or withdrawn beat keeps its served ports so nobody sees it twice
      r_sent <= r_sent | w_acc;
    end
  end

endmodule

// File: doc/genie_split_ex.md
# genie_split_ex

Packet-aware one-to-many fork node for the GENIE interconnect, the transmit-side counterpart of the merge node. One upstream valid/ready/eop stream is delivered to any subset of NO downstream ports, selected by a per-packet destination mask. Each beat goes to every selected destination, and each destination may accept it on a different cycle. The destination set is latched on the first beat of a packet and held until the eop beat completes, so a packet never changes destinations mid-stream.

## Interface
- NO, default 2: number of downstream ports; must be ≥ 2, elaboration error otherwise.
- WIDTH, default 1: payload width; 0 is legal (no data ports driven).
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- i_data  input  WIDTH  upstream payload.
- i_valid  input  1  upstream beat valid.
- o_ready  output  1  upstream ready; beat is consumed on a cycle with i_valid & o_ready.
- i_eop  input  1  upstream end-of-packet, qualified by i_valid.
- i_mask  input  NO  destination mask, one bit per downstream port, multi-hot allowed; sampled only on the first beat of a packet.
- o_valid  output  NO  per-port downstream valid.
- o_data  output  NO*WIDTH  i_data replicated into each port slice [WIDTH*k +: WIDTH].
- o_eop  output  NO  i_eop replicated to each port.
- i_ready  input  NO  per-port downstream ready.

## Operation
- State registers:
  - sent[NO]: port has already taken the current beat.
  - in_pkt: a packet is open.
  - lock_mask[NO]: destination set of the open packet.
- Effective mask: eff = in_pkt ? lock_mask : i_mask.
- Per-port valid: o_valid[k] = i_valid & eff[k] & ~sent[k].
- Per-port accept: acc[k] = o_valid[k] & i_ready[k].
- Beat completion: done = i_valid & ((eff & ~sent & ~i_ready) == 0). This holds when every selected port has either taken the beat earlier or accepts it this cycle.
- o_ready = done, combinational. It is the only upstream handshake path.
- Clock update when i_valid & done (beat consumed):
  - sent <= 0.
  - If i_eop: in_pkt <= 0.
  - Else: in_pkt <= 1, lock_mask <= eff.
- Clock update otherwise: sent <= sent | acc. in_pkt and lock_mask are unchanged.
- Zero mask (eff == 0): done = i_valid, so the beat is consumed and dropped the same cycle with no o_valid asserted. A zero-mask packet is dropped beat by beat.
- Single-beat packet (i_eop on first beat): in_pkt never sets; the next beat samples i_mask afresh.
- i_mask changes while in_pkt = 1 are ignored.
- Upstream violation (i_valid dropping mid-beat while sent ≠ 0): sent is retained. Ports already served are not re-offered when the beat reappears.
- Payload and eop are pure wires; no data storage.

## Timing
- Reset asserted (reset = 0):
  - sent = 0, in_pkt = 0, lock_mask = 0, taking effect immediately (asynchronous).
  - o_valid = 0 and o_ready = 0, gated by reset, independent of inputs.
  - o_data and o_eop still follow i_data and i_eop.
- Reset released: the first rising edge with reset = 1 is a normal cycle. No extra idle cycle is required.
- Reset mid-packet: partial-beat progress and the packet lock are discarded. After release, the head beat is offered to all ports in the current i_mask.
- Latency: 0 cycles, input to output. All outputs are combinational from inputs and state.
- Combinational paths: i_valid/i_mask → o_valid; i_ready → o_ready.
- Throughput: 1 beat/cycle when all selected ports are ready. A beat stalls until the slowest selected port accepts.
- Each port sees each beat exactly once. o_valid[k] deasserts the cycle after port k accepts, even if the beat is not yet complete.
- Simultaneous acceptance of the final outstanding ports plus i_eop: the beat completes, and the packet closes on that same edge.

## Test plan
- NO=3, WIDTH=8:
  - Stimulus: mask=3'b101, single beat 0xA5 with eop, all i_ready=1.
  - Required: o_valid=101 and o_ready=1 in the same cycle. Ports 0 and 2 see 0xA5 with eop. Port 1 never valid.
- Staggered accept:
  - Stimulus: mask=3'b111, beat 0x11; i_ready=001 in cycle 0, 100 in cycle 1, 010 in cycle 2.
  - Required: o_valid goes 111 → 110 → 010. o_ready=1 only in cycle 2. Each port accepts exactly once.
- Packet lock:
  - Stimulus: 3-beat packet; mask=011 on beat 0, i_mask changed to 100 on beats 1–2.
  - Required: all three beats go to ports 0 and 1 only. The next packet's first beat goes to port 2.
- Zero mask:
  - Stimulus: mask=000, 2-beat packet.
  - Required: o_ready=1 on both beats, o_valid stays 000, in_pkt clears after eop.
- Reset mid-beat:
  - Stimulus: mask=111, port 0 accepts, then reset=0 for one cycle, then released.
  - Required: o_valid=000 and o_ready=0 during reset. After release, o_valid=111 (beat re-offered to all ports).
- Back-to-back streaming:
  - Stimulus: NO=2, WIDTH=0, mask=11, all ready, 4 single-beat packets in consecutive cycles.
  - Required: 4 consumptions in 4 cycles, no bubbles.
